// File: rtl/fft_out_serializer_pkg.sv
// Shared FFT constants and the control-state encoding used by the FFT core and its output stage.
package fft_out_serializer_pkg;

  localparam int FFT_N    = 64;
  localparam int FFT_W    = 16;
  localparam int FFT_LOGN = $clog2(FFT_N);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } fft_state_e;

endpackage

// File: rtl/fft_out_serializer_bitrev.sv
// Combinational bit-reversal of an FFT index; shared with the FFT core.
module fft_bitrev
  import fft_out_serializer_pkg::*;
#(
  parameter int WIDTH = FFT_LOGN
) (
  input  logic [WIDTH-1:0] i_idx,
  output logic [WIDTH-1:0] o_idx
);

  always_comb begin
    o_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_idx[i] = i_idx[WIDTH-1-i];
    end
  end

endmodule

// File: rtl/fft_out_serializer.sv
// Collects N/2 sample pairs into a frame buffer, then streams the N samples out
// one per handshake, optionally in bit-reversed buffer order.
module fft_out_serializer
  import fft_out_serializer_pkg::*;
#(
  parameter int N      = FFT_N,
  parameter int W      = FFT_W,
  parameter bit BITREV = 1'b0
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  pair_valid,
  input  logic signed [W-1:0]   re0,
  input  logic signed [W-1:0]   im0,
  input  logic signed [W-1:0]   re1,
  input  logic signed [W-1:0]   im1,
  output logic                  s_valid,
  input  logic                  s_ready,
  output logic signed [W-1:0]   s_re,
  output logic signed [W-1:0]   s_im,
  output logic [$clog2(N)-1:0]  s_index,
  output logic                  s_last,
  output logic                  busy,
  output logic                  ovf
);

  localparam int LOGN = $clog2(N);
  localparam int PCW  = LOGN - 1;

  fft_state_e              r_state;
  fft_state_e              w_next;
  logic [PCW-1:0]          r_pcnt;
  logic [LOGN-1:0]         r_rd;
  logic                    r_ovf;
  logic signed [W-1:0]     r_buf_re [N];
  logic signed [W-1:0]     r_buf_im [N];

  logic                    w_hs;
  logic                    w_hs_last;
  logic                    w_accept;
  logic                    w_drop;
  logic                    w_last_pair;
  logic [LOGN-1:0]         w_rev;
  logic [LOGN-1:0]         w_rd_addr;
  logic [LOGN-1:0]         w_wr_even;
  logic [LOGN-1:0]         w_wr_odd;

  fft_bitrev #(.WIDTH(LOGN)) u_bitrev (
    .i_idx (r_rd),
    .o_idx (w_rev)
  );

  assign w_last_pair = (r_pcnt == PCW'(N/2 - 1));
  assign w_wr_even   = {r_pcnt, 1'b0};
  assign w_wr_odd    = {r_pcnt, 1'b1};
  assign w_rd_addr   = BITREV ? w_rev : r_rd;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A pair arriving with the final handshake opens the next frame instead of being dropped.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = ST_FILL;
      ST_FILL:  if (w_accept && w_last_pair) w_next = ST_DRAIN;
      ST_DRAIN: if (w_hs_last) w_next = w_accept ? ST_FILL : ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_hs      = 1'b0;
    w_hs_last = 1'b0;
    w_accept  = 1'b0;
    w_drop    = 1'b0;
    case (r_state)
      ST_IDLE, ST_FILL: w_accept = pair_valid;
      ST_DRAIN: begin
        w_hs      = s_ready;
        w_hs_last = s_ready && (r_rd == LOGN'(N - 1));
        w_accept  = pair_valid && w_hs_last;
        w_drop    = pair_valid && !w_hs_last;
      end
      default: ;
    endcase
  end

  // Pair count and read index wrap naturally at the frame boundary.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_pcnt <= '0;
      r_rd   <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_accept) r_pcnt <= r_pcnt + 1'b1;
      if (w_hs)     r_rd   <= r_rd + 1'b1;
      if (w_drop)   r_ovf  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf_re[w_wr_even] <= re0;
      r_buf_im[w_wr_even] <= im0;
      r_buf_re[w_wr_odd]  <= re1;
      r_buf_im[w_wr_odd]  <= im1;
    end
  end

  // Data outputs are gated by state so reset zeroes them without clearing the buffer.
  assign s_valid = (r_state == ST_DRAIN);
  assign busy    = (r_state != ST_IDLE);
  assign s_index = r_rd;
  assign s_last  = s_valid && (r_rd == LOGN'(N - 1));
  assign s_re    = s_valid ? r_buf_re[w_rd_addr] : '0;
  assign s_im    = s_valid ? r_buf_im[w_rd_addr] : '0;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_fft_out_serializer.sv
// Directed bench for fft_out_serializer: linear and bit-reversed instances share stimulus,
// each with its own scoreboard queue drained by a handshake monitor.
module tb_fft_out_serializer;

  localparam int N    = 64;
  localparam int W    = 16;
  localparam int LOGN = 6;

  logic                clk = 1'b0;
  logic                nrst;
  logic                pair_valid;
  logic                s_ready;
  logic signed [W-1:0] re0, im0, re1, im1;

  logic                v0, last0, busy0, ovf0;
  logic signed [W-1:0] sre0, sim0;
  logic [LOGN-1:0]     idx0;
  logic                v1, last1, busy1, ovf1;
  logic signed [W-1:0] sre1, sim1;
  logic [LOGN-1:0]     idx1;

  typedef struct packed {
    logic [W-1:0]    re;
    logic [W-1:0]    im;
    logic [LOGN-1:0] idx;
    logic            last;
  } smp_t;

  smp_t q0[$];
  smp_t q1[$];
  smp_t m_e0, m_e1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fft_out_serializer #(.N(N), .W(W), .BITREV(1'b0)) u_dut (
    .clk(clk), .nrst(nrst), .pair_valid(pair_valid),
    .re0(re0), .im0(im0), .re1(re1), .im1(im1),
    .s_valid(v0), .s_ready(s_ready), .s_re(sre0), .s_im(sim0),
    .s_index(idx0), .s_last(last0), .busy(busy0), .ovf(ovf0)
  );

  fft_out_serializer #(.N(N), .W(W), .BITREV(1'b1)) u_rev (
    .clk(clk), .nrst(nrst), .pair_valid(pair_valid),
    .re0(re0), .im0(im0), .re1(re1), .im1(im1),
    .s_valid(v1), .s_ready(s_ready), .s_re(sre1), .s_im(sim1),
    .s_index(idx1), .s_last(last1), .busy(busy1), .ovf(ovf1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic int brev(input int r);
    int b;
    b = 0;
    for (int i = 0; i < LOGN; i++) if (r[i]) b = b | (1 << (LOGN - 1 - i));
    return b;
  endfunction

  task automatic push_frame(input int base);
    smp_t e;
    for (int r = 0; r < N; r++) begin
      e.re   = W'(base + r);
      e.im   = W'(-(base + r));
      e.idx  = LOGN'(r);
      e.last = (r == N - 1);
      q0.push_back(e);
      e.re   = W'(base + brev(r));
      e.im   = W'(-(base + brev(r)));
      q1.push_back(e);
    end
  endtask

  // Handshake monitor: every accepted sample must match the head of its queue.
  always @(negedge clk) begin
    if (nrst && s_ready) begin
      if (v0) begin
        if (q0.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL linear extra sample: got index %0d, want none", idx0);
        end else begin
          m_e0 = q0.pop_front();
          chk("linear sample", 64'({sre0, sim0, idx0, last0}), 64'(m_e0));
        end
      end
      if (v1) begin
        if (q1.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL bitrev extra sample: got index %0d, want none", idx1);
        end else begin
          m_e1 = q1.pop_front();
          chk("bitrev sample", 64'({sre1, sim1, idx1, last1}), 64'(m_e1));
        end
      end
    end
  end

  task automatic do_reset();
    nrst = 1'b0;
    #1;
    chk("reset outputs linear", 64'({v0, last0, idx0, sre0, sim0, busy0, ovf0}), 64'(0));
    chk("reset outputs bitrev", 64'({v1, last1, idx1, sre1, sim1, busy1, ovf1}), 64'(0));
    q0.delete();
    q1.delete();
    pair_valid = 1'b0;
    s_ready    = 1'b1;
    @(posedge clk); #1;
    nrst = 1'b1;
  endtask

  task automatic send_frame(input int start_k, input int base, input int gap);
    for (int k = start_k; k < N/2; k++) begin
      pair_valid = 1'b1;
      re0 = W'(base + 2*k);
      im0 = W'(-(base + 2*k));
      re1 = W'(base + 2*k + 1);
      im1 = W'(-(base + 2*k + 1));
      if (k == N/2 - 1) chk("s_valid low before last pair", 64'(v0), 64'(0));
      @(posedge clk); #1;
      pair_valid = 1'b0;
      if (k == N/2 - 1) begin
        chk("s_valid 1 cycle after last pair", 64'(v0), 64'(1));
        chk("bitrev s_valid after last pair", 64'(v1), 64'(1));
        chk("busy during drain", 64'(busy0), 64'(1));
      end else begin
        repeat (gap) begin @(posedge clk); #1; end
      end
    end
    push_frame(base);
  endtask

  task automatic drain(input bit bp, input int drop_at, input int rst_at,
                       input int chain_base, input bit rev_pts, output int cycles);
    bit done;
    bit chained;
    done    = 1'b0;
    chained = 1'b0;
    cycles  = 0;
    for (int g = 0; g < 400 && !done; g++) begin
      if (!v0) begin
        done = 1'b1;
      end else begin
        s_ready    = bp ? cycles[0] : 1'b1;
        pair_valid = 1'b0;
        if (rev_pts) begin
          case (int'(idx1))
            1:  chk("bitrev index 1 value", 64'(sre1), 64'(32));
            2:  chk("bitrev index 2 value", 64'(sre1), 64'(16));
            63: chk("bitrev index 63 value", 64'(sre1), 64'(63));
            default: ;
          endcase
        end
        if (rst_at >= 0 && int'(idx0) == rst_at) begin
          do_reset();
          return;
        end
        if (drop_at >= 0 && int'(idx0) == drop_at) begin
          pair_valid = 1'b1;
          re0 = 16'sh1234; im0 = 16'sh5678; re1 = -16'sh0abc; im1 = 16'sh7fff;
        end
        if (chain_base >= 0 && int'(idx0) == N - 1) begin
          pair_valid = 1'b1;
          re0 = W'(chain_base);     im0 = W'(-chain_base);
          re1 = W'(chain_base + 1); im1 = W'(-(chain_base + 1));
          chained = 1'b1;
        end
        cycles++;
        @(posedge clk); #1;
        pair_valid = 1'b0;
        if (chained) done = 1'b1;
      end
    end
    s_ready = 1'b1;
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL drain timeout: got %0d cycles without end, want end of frame", cycles);
    end
  endtask

  task automatic post_drain(input string name);
    chk({name, " busy low"}, 64'(busy0), 64'(0));
    chk({name, " linear queue empty"}, 64'(q0.size()), 64'(0));
    chk({name, " bitrev queue empty"}, 64'(q1.size()), 64'(0));
  endtask

  initial begin
    int cyc;
    nrst = 1'b1; pair_valid = 1'b0; s_ready = 1'b1;
    re0 = '0; im0 = '0; re1 = '0; im1 = '0;
    #3;
    do_reset();

    // Back-to-back ramp
    send_frame(0, 0, 0);
    drain(1'b0, -1, -1, -1, 1'b1, cyc);
    chk("ramp drain cycles", 64'(cyc), 64'(64));
    post_drain("ramp");
    chk("ramp ovf clear", 64'(ovf0), 64'(0));

    // Alternating backpressure
    send_frame(0, 0, 0);
    drain(1'b1, -1, -1, -1, 1'b0, cyc);
    chk("backpressure drain cycles", 64'(cyc), 64'(128));
    post_drain("backpressure");

    // Gapped fill, one pair every third cycle
    send_frame(0, 0, 2);
    drain(1'b0, -1, -1, -1, 1'b0, cyc);
    chk("gapped drain cycles", 64'(cyc), 64'(64));
    post_drain("gapped");

    // Pair dropped mid-drain sets sticky overflow
    send_frame(0, 0, 0);
    drain(1'b0, 10, -1, -1, 1'b0, cyc);
    chk("ovf set linear", 64'(ovf0), 64'(1));
    chk("ovf set bitrev", 64'(ovf1), 64'(1));
    post_drain("overflow");
    send_frame(0, 200, 0);
    drain(1'b0, -1, -1, -1, 1'b0, cyc);
    chk("ovf sticky", 64'(ovf0), 64'(1));
    post_drain("after overflow");

    // Asynchronous reset mid-drain, then a clean frame
    send_frame(0, 0, 0);
    drain(1'b0, -1, 20, -1, 1'b0, cyc);
    send_frame(0, 300, 0);
    drain(1'b0, -1, -1, -1, 1'b0, cyc);
    chk("post-reset drain cycles", 64'(cyc), 64'(64));
    post_drain("after drain reset");

    // Reset mid-fill restarts capture at pair 0
    for (int k = 0; k < 10; k++) begin
      pair_valid = 1'b1;
      re0 = 16'sh0100; im0 = 16'sh0200; re1 = 16'sh0300; im1 = 16'sh0400;
      @(posedge clk); #1;
    end
    pair_valid = 1'b0;
    chk("busy mid-fill", 64'(busy0), 64'(1));
    do_reset();
    send_frame(0, 400, 1);
    drain(1'b0, -1, -1, -1, 1'b0, cyc);
    post_drain("after fill reset");

    // Pair arriving with the last handshake starts the next frame
    send_frame(0, 500, 0);
    drain(1'b0, -1, -1, 600, 1'b0, cyc);
    chk("chain no ovf", 64'(ovf0), 64'(0));
    chk("chain busy held", 64'(busy0), 64'(1));
    chk("chain s_valid low", 64'(v0), 64'(0));
    send_frame(1, 600, 0);
    drain(1'b0, -1, -1, -1, 1'b0, cyc);
    post_drain("chained");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
